pipe_stage_buf: RTL and testbench

- Parametrised pipeline-stage buffer; the general successor to the fixed IF/ID register.
- Carries WIDTH-bit payloads (instruction word plus PC, packed by the instantiating stage) between any two stages of the MIPS32 pipeline.
- Adds a valid/ready handshake, a DEPTH-entry elastic (skid) store, hold and flush, and NOP bubble insertion.
- Sits between adjacent stages (IF/ID, ID/EX, ...) so a downstream stall does not need a combinational stall path back through every stage.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_buf_ptr.sv | 50 +++++
 rtl/pipe_stage_buf.sv | 77 +++++++
 tb/tb_pipe_stage_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline payload types and constants for the MIPS32 stage buffers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // MIPS sll $0,$0,0 encodes as all zeros and serves as the bubble instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID payload: fetched instruction word plus its PC.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_payload_t;

    localparam int IF_ID_WIDTH = $bits(if_id_payload_t);

    // ID/EX payload for the stages that adopt the elastic buffer next.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } id_ex_payload_t;

    localparam int ID_EX_WIDTH = $bits(id_ex_payload_t);

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrap-around read/write pointers and occupancy counter for a DEPTH-entry buffer.
// Latency: pointers and count update on the clock edge after push/pop/clear.
// Backpressure: none here; the caller must not push when full or pop when empty.
module pipe_buf_ptr #(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Advance pointers and occupancy; clear overrides any same-cycle push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer with valid/ready handshake, hold, flush and NOP bubbles.
// Latency: one cycle from push to out_valid when empty; full throughput for DEPTH >= 2.
// Backpressure: registered in_ready drops when the next occupancy reaches DEPTH.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter  int               WIDTH     = IF_ID_WIDTH,
    parameter  int               DEPTH     = 2,
    parameter  logic [WIDTH-1:0] NOP_VALUE = '0,
    localparam int               PW        = $clog2(DEPTH),
    localparam int               CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             in_ready_nxt;

    // Flush discards both sides of the handshake; hold only freezes the output side.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~hold & ~flush;

    pipe_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .clear  (flush),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Next in_ready = (next occupancy < DEPTH), derived without any out_ready-to-in_ready comb path leaving the stage.
    always_comb begin
        in_ready_nxt = ~full;
        if (flush)     in_ready_nxt = 1'b1;
        else if (pop)  in_ready_nxt = 1'b1;
        else if (push) in_ready_nxt = (count != CW'(DEPTH - 1));
    end

    // Registered in_ready; comes out of reset able to accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready <= 1'b1;
        else       in_ready <= in_ready_nxt;
    end

    // Payload storage carries no reset; empty entries are never observed on out_data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Bubble insertion: empty buffer presents NOP_VALUE instead of stale storage.
    assign out_valid = ~empty;
    assign out_data  = empty ? NOP_VALUE : mem[rd_ptr];

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset;

    // DEPTH=2 instance
    logic        a_flush, a_hold, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    // DEPTH=3 instance for wrap-around
    logic        b_flush, b_hold, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(64), .DEPTH(2), .NOP_VALUE(64'h0)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (a_flush),
        .hold      (a_hold),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .count     (a_count)
    );

    pipe_stage_buf #(.WIDTH(64), .DEPTH(3), .NOP_VALUE(64'h0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (b_flush),
        .hold      (b_hold),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sdat(input int i);
        return {32'(i + 1), 32'h0040_0000 + 32'(4 * i)};
    endfunction

    function automatic logic [63:0] wdat(input int i);
        return {32'h0000_1000 + 32'(i), 32'h0040_0000 + 32'(4 * i)};
    endfunction

    localparam logic [63:0] VA = 64'hAAAA_0001_0040_0100;
    localparam logic [63:0] VB = 64'hBBBB_0002_0040_0104;
    localparam logic [63:0] VC = 64'hCCCC_0003_0040_0108;
    localparam logic [63:0] H1 = 64'h2008_0005_0040_0010;
    localparam logic [63:0] H2 = 64'h2009_0006_0040_0014;

    logic [63:0] q[$];
    int          pushed, popped;
    logic        m_rdy, do_push, do_pop;

    initial begin
        reset = 1'b1;
        a_flush = 0; a_hold = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_hold = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_count",    64'(a_count),     64'd0);
        chk("rst_valid",    64'(a_out_valid), 64'd0);
        chk("rst_data",     a_out_data,       64'h0);
        chk("rst_in_ready", 64'(a_in_ready),  64'd1);

        // Streaming: one output per cycle, one-cycle latency
        a_out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1;
            a_in_data  = sdat(i);
            tick;
            chk($sformatf("strm_data%0d", i), a_out_data, sdat(i));
            chk($sformatf("strm_vld%0d", i),  64'(a_out_valid), 64'd1);
            chk($sformatf("strm_rdy%0d", i),  64'(a_in_ready),  64'd1);
        end
        a_in_valid = 0;
        tick;
        chk("strm_drain_count", 64'(a_count), 64'd0);
        chk("strm_drain_data",  a_out_data,   64'h0);

        // Backpressure / full
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = VA; tick;
        a_in_data = VB; tick;
        chk("bp_count_full", 64'(a_count),    64'd2);
        chk("bp_in_ready0",  64'(a_in_ready), 64'd0);
        a_in_data = VC; tick;
        chk("bp_c_ignored",  64'(a_count),    64'd2);
        chk("bp_head_a",     a_out_data,      VA);
        a_out_ready = 1; tick;
        chk("bp_after_pop_count", 64'(a_count),    64'd1);
        chk("bp_after_pop_data",  a_out_data,      VB);
        chk("bp_in_ready1",       64'(a_in_ready), 64'd1);
        a_out_ready = 0; tick;
        chk("bp_c_accepted", 64'(a_count), 64'd2);
        a_in_valid = 0; a_out_ready = 1; tick;
        chk("bp_seq_c", a_out_data, VC);
        tick;
        chk("bp_empty", 64'(a_count), 64'd0);

        // Hold
        a_out_ready = 0; a_in_valid = 1; a_in_data = H1; tick;
        a_in_valid = 0; a_hold = 1; a_out_ready = 1; tick;
        chk("hold_data_c1",  a_out_data,   H1);
        chk("hold_count_c1", 64'(a_count), 64'd1);
        a_in_valid = 1; a_in_data = H2; tick;
        chk("hold_push_count", 64'(a_count), 64'd2);
        a_in_valid = 0; tick;
        chk("hold_data_c3",  a_out_data,   H1);
        chk("hold_count_c3", 64'(a_count), 64'd2);
        chk("hold_valid",    64'(a_out_valid), 64'd1);
        a_hold = 0; tick;
        chk("hold_rel_data", a_out_data,   H2);
        tick;
        chk("hold_rel_empty", 64'(a_out_valid), 64'd0);

        // Flush with count=2 and in_valid high
        a_out_ready = 0; a_in_valid = 1; a_in_data = VA; tick;
        a_in_data = VB; tick;
        a_in_data = VC; a_flush = 1; tick;
        a_flush = 0; a_in_valid = 0;
        chk("fl_count",    64'(a_count),     64'd0);
        chk("fl_valid",    64'(a_out_valid), 64'd0);
        chk("fl_data",     a_out_data,       64'h0);
        chk("fl_in_ready", 64'(a_in_ready),  64'd1);

        // Flush + hold with an acceptable push in the same cycle
        a_in_valid = 1; a_in_data = VA; tick;
        a_in_data = VB; a_out_ready = 1; a_hold = 1; a_flush = 1; tick;
        a_flush = 0; a_hold = 0; a_in_valid = 0; a_out_ready = 0;
        chk("flh_count",    64'(a_count),     64'd0);
        chk("flh_valid",    64'(a_out_valid), 64'd0);
        chk("flh_data",     a_out_data,       64'h0);
        chk("flh_in_ready", 64'(a_in_ready),  64'd1);

        // Async reset mid-stream with count=2, between edges
        a_in_valid = 1; a_in_data = VA; tick;
        a_in_data = VB; tick;
        a_in_valid = 0;
        chk("pre_rst_count", 64'(a_count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_count",    64'(a_count),     64'd0);
        chk("arst_valid",    64'(a_out_valid), 64'd0);
        chk("arst_data",     a_out_data,       64'h0);
        chk("arst_in_ready", 64'(a_in_ready),  64'd1);
        tick;
        reset = 1'b0;
        tick;

        // Wrap-around on DEPTH=3: push 2, pop 1 pattern through 20 entries
        pushed = 0; popped = 0; m_rdy = 1;
        for (int cyc = 0; cyc < 300 && popped < 20; cyc++) begin
            b_in_valid  = (pushed < 20);
            b_in_data   = wdat(pushed);
            b_out_ready = (cyc % 3 == 2) || (pushed >= 20);
            do_push = b_in_valid && m_rdy;
            do_pop  = b_out_ready && (q.size() > 0);
            tick;
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(wdat(pushed));
                pushed++;
            end
            m_rdy = (q.size() < 3);
            chk($sformatf("wr_count%0d", cyc), 64'(b_count), 64'(q.size()));
            chk($sformatf("wr_data%0d", cyc), b_out_data, (q.size() > 0) ? q[0] : 64'h0);
            chk($sformatf("wr_rdy%0d", cyc), 64'(b_in_ready), 64'(m_rdy));
        end
        b_in_valid = 0; b_out_ready = 0;
        if (popped < 20) chk("wr_timeout", 64'(popped), 64'd20);
        chk("wr_final_valid", 64'(b_out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
